// File: rtl/fifo_pkg.sv
// Shared types and helper functions for the flexible-depth FIFO.
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   function automatic int calc_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic fifo_mode_e mode_of(input int fwft);
      return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
   endfunction

   // Wrap by compare so any depth works, not just powers of two.
   function automatic int ptr_next(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Read-before-write on a shared address: the read returns the old word.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
   end

   assign rd_data_o = r_rd_data;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, standard or first-word-fall-through
// read, fill count, flush and sticky overflow/underflow flags.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   parameter int  FWFT  = 0,
   localparam int CW    = calc_cw(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             wr_dv_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [CW-1:0]    AF_level_i,
   output logic             AF_flag_o,
   output logic             full_o,
   input  logic             rd_en_i,
   output logic             rd_dv_o,
   output logic [WIDTH-1:0] rd_data_o,
   input  logic [CW-1:0]    AE_level_i,
   output logic             AE_flag_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o,
   output logic             overflow_o,
   output logic             underflow_o,
   input  logic             err_clr_i
);

   localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam fifo_mode_e      MODE     = mode_of(FWFT);
   localparam bit              IS_FWFT  = (MODE == FIFO_FWFT);
   localparam logic [CW-1:0]   DEPTH_CW = CW'(DEPTH);

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_rd_dv;
   logic             r_sel_byp;
   logic [WIDTH-1:0] r_byp_data;
   logic             r_ovf;
   logic             r_udf;

   logic [WIDTH-1:0] w_ram_q;
   logic             w_full;
   logic             w_empty;
   logic             w_mem_empty;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_out_free;
   logic             w_ram_rd;
   logic             w_ram_wr;
   logic             w_byp;
   logic             w_ovf_set;
   logic             w_udf_set;

   assign w_full  = (r_count == DEPTH_CW);
   assign w_empty = (r_count == '0);
   // In FWFT mode the output register holds one of the counted entries.
   assign w_mem_empty = (r_count == {{(CW-1){1'b0}}, r_rd_dv});

   always_comb begin
      w_rd_acc   = 1'b0;
      w_udf_set  = 1'b0;
      w_wr_acc   = 1'b0;
      w_ovf_set  = 1'b0;
      w_out_free = 1'b0;
      w_ram_rd   = 1'b0;
      w_byp      = 1'b0;
      w_ram_wr   = 1'b0;

      if (IS_FWFT) begin
         w_rd_acc  = rd_en_i && r_rd_dv && !flush_i;
         w_udf_set = rd_en_i && !r_rd_dv && !flush_i;
      end else begin
         w_rd_acc  = rd_en_i && !w_empty && !flush_i;
         w_udf_set = rd_en_i && w_empty && !flush_i;
      end

      w_wr_acc  = wr_dv_i && !flush_i && (!w_full || w_rd_acc);
      w_ovf_set = wr_dv_i && !flush_i && !w_wr_acc;

      if (IS_FWFT) begin
         // Refill the output from RAM when it frees up; with nothing in RAM a
         // same-cycle write skips storage and lands in the bypass register.
         w_out_free = !r_rd_dv || w_rd_acc;
         w_ram_rd   = w_out_free && !w_mem_empty && !flush_i;
         w_byp      = w_out_free && w_mem_empty && w_wr_acc;
      end else begin
         w_ram_rd   = w_rd_acc;
      end

      w_ram_wr = w_wr_acc && !w_byp;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_dv    <= 1'b0;
         r_sel_byp  <= 1'b1;
         r_byp_data <= '0;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
      end else begin
         r_ovf <= w_ovf_set | (r_ovf & ~err_clr_i);
         r_udf <= w_udf_set | (r_udf & ~err_clr_i);
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rd_dv  <= 1'b0;
         end else begin
            if (w_ram_wr) r_wr_ptr <= AW'(ptr_next(int'(r_wr_ptr), DEPTH));
            if (w_ram_rd) r_rd_ptr <= AW'(ptr_next(int'(r_rd_ptr), DEPTH));
            r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
            if (IS_FWFT) r_rd_dv <= w_out_free ? (w_ram_rd || w_byp) : 1'b1;
            else         r_rd_dv <= w_rd_acc;
            // Selecting the zeroed bypass register keeps rd_data_o at 0 after reset.
            if (w_byp) begin
               r_sel_byp  <= 1'b1;
               r_byp_data <= wr_data_i;
            end else if (w_ram_rd) begin
               r_sel_byp  <= 1'b0;
            end
         end
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (w_ram_wr),
      .wr_addr_i (r_wr_ptr),
      .wr_data_i (wr_data_i),
      .rd_en_i   (w_ram_rd),
      .rd_addr_i (r_rd_ptr),
      .rd_data_o (w_ram_q)
   );

   assign rd_data_o   = r_sel_byp ? r_byp_data : w_ram_q;
   assign rd_dv_o     = r_rd_dv;
   assign count_o     = r_count;
   assign full_o      = w_full;
   assign empty_o     = w_empty;
   assign AF_flag_o   = (r_count >= AF_level_i);
   assign AE_flag_o   = (r_count <= AE_level_i);
   assign overflow_o  = r_ovf;
   assign underflow_o = r_udf;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a DEPTH=4 standard instance and a DEPTH=5 FWFT instance,
// read data checked by per-instance monitors against queued expected words.
module tb_fifo_flex;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       a_rst, a_flush, a_wr, a_rd, a_clr;
   logic [7:0] a_wdata, a_rdata;
   logic [2:0] a_af_lvl, a_ae_lvl, a_count;
   logic       a_af, a_full, a_dv, a_ae, a_empty, a_ovf, a_udf;

   logic       b_rst, b_flush, b_wr, b_rd, b_clr;
   logic [7:0] b_wdata, b_rdata;
   logic [2:0] b_af_lvl, b_ae_lvl, b_count;
   logic       b_af, b_full, b_dv, b_ae, b_empty, b_ovf, b_udf;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_std (
      .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush),
      .wr_dv_i(a_wr), .wr_data_i(a_wdata),
      .AF_level_i(a_af_lvl), .AF_flag_o(a_af), .full_o(a_full),
      .rd_en_i(a_rd), .rd_dv_o(a_dv), .rd_data_o(a_rdata),
      .AE_level_i(a_ae_lvl), .AE_flag_o(a_ae), .empty_o(a_empty),
      .count_o(a_count), .overflow_o(a_ovf), .underflow_o(a_udf),
      .err_clr_i(a_clr)
   );

   fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_fwft (
      .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush),
      .wr_dv_i(b_wr), .wr_data_i(b_wdata),
      .AF_level_i(b_af_lvl), .AF_flag_o(b_af), .full_o(b_full),
      .rd_en_i(b_rd), .rd_dv_o(b_dv), .rd_data_o(b_rdata),
      .AE_level_i(b_ae_lvl), .AE_flag_o(b_ae), .empty_o(b_empty),
      .count_o(b_count), .overflow_o(b_ovf), .underflow_o(b_udf),
      .err_clr_i(b_clr)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (a_dv) begin
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL std_rd_unexpected: got 0x%0h, expected no read", a_rdata);
         end else begin
            chk("std_rd_data", int'(a_rdata), int'(exp_a.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (b_dv && b_rd) begin
         if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fwft_pop_unexpected: got 0x%0h, expected no pop", b_rdata);
         end else begin
            chk("fwft_pop_data", int'(b_rdata), int'(exp_b.pop_front()));
         end
      end
   end

   task automatic cyc_a(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic clr);
      a_wr = wr; a_wdata = d; a_rd = rd; a_flush = fl; a_clr = clr;
      @(posedge clk); #1;
      a_wr = 1'b0; a_rd = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
   endtask

   task automatic rd_a(input logic [7:0] exp);
      exp_a.push_back(exp);
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic cyc_b(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
      b_wr = wr; b_wdata = d; b_rd = rd; b_clr = clr;
      @(posedge clk); #1;
      b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
   endtask

   task automatic pop_b(input logic [7:0] exp);
      exp_b.push_back(exp);
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_rst = 1'b1; a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_wdata = '0;
      b_rst = 1'b1; b_flush = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_wdata = '0;
      a_af_lvl = 3'd3; a_ae_lvl = 3'd1;
      b_af_lvl = 3'd4; b_ae_lvl = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      a_rst = 1'b0; b_rst = 1'b0;

      // ---------------- standard mode, DEPTH=4 ----------------
      chk("std_rst_count", a_count, 0);
      chk("std_rst_empty", a_empty, 1);
      chk("std_rst_full", a_full, 0);
      chk("std_rst_dv", a_dv, 0);
      chk("std_rst_data", a_rdata, 0);
      chk("std_rst_ovf", a_ovf, 0);
      chk("std_rst_udf", a_udf, 0);
      chk("std_rst_ae", a_ae, 1);
      chk("std_rst_af", a_af, 0);

      cyc_a(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
      chk("std_wr1_count", a_count, 1);
      chk("std_wr1_empty", a_empty, 0);
      repeat (4) cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      rd_a(8'hAB);
      chk("std_rd1_dv", a_dv, 1);
      chk("std_rd1_data", a_rdata, 8'hAB);
      chk("std_rd1_empty", a_empty, 1);
      chk("std_rd1_count", a_count, 0);
      cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("std_dv_pulse", a_dv, 0);
      chk("std_data_hold", a_rdata, 8'hAB);

      for (int i = 1; i <= 3; i++) cyc_a(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("std_af_at3", a_af, 1);
      chk("std_full_at3", a_full, 0);
      cyc_a(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
      chk("std_full_at4", a_full, 1);
      chk("std_count4", a_count, 4);
      chk("std_ae_at4", a_ae, 0);
      cyc_a(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      chk("std_ovf_set", a_ovf, 1);
      chk("std_ovf_count", a_count, 4);
      for (int i = 1; i <= 4; i++) rd_a(8'(i));
      cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("std_drain_empty", a_empty, 1);
      cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("std_ovf_clr", a_ovf, 0);

      for (int i = 1; i <= 4; i++) cyc_a(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
      exp_a.push_back(8'h61);
      cyc_a(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("std_rdwr_full_count", a_count, 4);
      chk("std_rdwr_full_ovf", a_ovf, 0);
      chk("std_rdwr_full_flag", a_full, 1);
      rd_a(8'h62); rd_a(8'h63); rd_a(8'h64); rd_a(8'h55);
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("std_udf_set", a_udf, 1);
      chk("std_udf_count", a_count, 0);
      cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("std_udf_clr", a_udf, 0);
      chk("std_ovf_still_clr", a_ovf, 0);
      cyc_a(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      chk("std_nobypass_udf", a_udf, 1);
      chk("std_nobypass_dv", a_dv, 0);
      chk("std_nobypass_count", a_count, 1);
      exp_a.push_back(8'h5A);
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("std_clr_udf", a_udf, 0);
      cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("std_set_wins", a_udf, 1);

      for (int i = 1; i <= 3; i++) cyc_a(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
      chk("std_pre_flush_count", a_count, 3);
      rd_a(8'h71);
      cyc_a(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      chk("std_flush_count", a_count, 0);
      chk("std_flush_empty", a_empty, 1);
      chk("std_flush_dv", a_dv, 0);
      chk("std_flush_udf", a_udf, 1);
      chk("std_flush_ovf", a_ovf, 0);
      cyc_a(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      rd_a(8'h42);
      chk("std_post_flush_data", a_rdata, 8'h42);

      cyc_a(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
      cyc_a(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
      rd_a(8'h81);
      #5;
      a_wr = 1'b1; a_wdata = 8'h83;
      a_rst = 1'b1;
      #1;
      chk("std_async_rst_count", a_count, 0);
      chk("std_async_rst_empty", a_empty, 1);
      chk("std_async_rst_full", a_full, 0);
      chk("std_async_rst_dv", a_dv, 0);
      chk("std_async_rst_data", a_rdata, 0);
      chk("std_async_rst_udf", a_udf, 0);
      chk("std_async_rst_ovf", a_ovf, 0);
      @(posedge clk); #1;
      a_rst = 1'b0; a_wr = 1'b0;
      chk("std_rst_held_count", a_count, 0);

      // ---------------- FWFT mode, DEPTH=5 ----------------
      chk("fwft_rst_dv", b_dv, 0);
      chk("fwft_rst_empty", b_empty, 1);
      chk("fwft_rst_count", b_count, 0);
      chk("fwft_rst_ae", b_ae, 1);
      chk("fwft_rst_data", b_rdata, 0);

      cyc_b(1'b1, 8'h10, 1'b0, 1'b0);
      chk("fwft_first_dv", b_dv, 1);
      chk("fwft_first_data", b_rdata, 8'h10);
      chk("fwft_first_count", b_count, 1);
      chk("fwft_first_ae", b_ae, 0);
      cyc_b(1'b1, 8'h11, 1'b0, 1'b0);
      chk("fwft_second_dv", b_dv, 1);
      chk("fwft_second_head", b_rdata, 8'h10);
      chk("fwft_second_count", b_count, 2);
      pop_b(8'h10);
      chk("fwft_nobubble_dv", b_dv, 1);
      chk("fwft_nobubble_data", b_rdata, 8'h11);
      chk("fwft_nobubble_count", b_count, 1);
      pop_b(8'h11);
      chk("fwft_drain_dv", b_dv, 0);
      chk("fwft_drain_empty", b_empty, 1);

      for (int i = 0; i < 4; i++) cyc_b(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      chk("fwft_wrap_fill", b_count, 4);
      for (int i = 0; i < 8; i++) begin
         exp_b.push_back(8'h20 + 8'(i));
         cyc_b(1'b1, 8'h24 + 8'(i), 1'b1, 1'b0);
         chk("fwft_wrap_count", b_count, 4);
      end
      for (int i = 8; i < 12; i++) pop_b(8'h20 + 8'(i));
      chk("fwft_wrap_empty", b_empty, 1);
      chk("fwft_wrap_dv", b_dv, 0);

      for (int i = 0; i < 4; i++) cyc_b(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      chk("fwft_af_at4", b_af, 1);
      chk("fwft_full_at4", b_full, 0);
      cyc_b(1'b1, 8'h34, 1'b0, 1'b0);
      chk("fwft_full_at5", b_full, 1);
      chk("fwft_count5", b_count, 5);
      cyc_b(1'b1, 8'h35, 1'b0, 1'b0);
      chk("fwft_ovf_set", b_ovf, 1);
      chk("fwft_ovf_count", b_count, 5);
      exp_b.push_back(8'h30);
      cyc_b(1'b1, 8'h36, 1'b1, 1'b0);
      chk("fwft_popwr_full_count", b_count, 5);
      pop_b(8'h31); pop_b(8'h32); pop_b(8'h33); pop_b(8'h34); pop_b(8'h36);
      chk("fwft_final_empty", b_empty, 1);
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fwft_udf_set", b_udf, 1);
      cyc_b(1'b0, 8'h00, 1'b0, 1'b1);
      chk("fwft_udf_clr", b_udf, 0);
      chk("fwft_ovf_clr", b_ovf, 0);

      repeat (2) @(posedge clk);
      chk("std_queue_drained", exp_a.size(), 0);
      chk("fwft_queue_drained", exp_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Second-generation synchronous FIFO for the iCE40 component library.
- Generalises the single-mode FIFO with:
  - arbitrary (non-power-of-2) depth
  - selectable standard or first-word-fall-through (FWFT) read mode
  - fill-count output, synchronous flush, and sticky overflow/underflow error flags.
- Sits between UART/SPI front ends and their consumers as the standard buffering element.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, any integer, not restricted to powers of 2)
FWFT, 0, 0 = standard read (data one cycle after rd_en_i); 1 = first-word-fall-through
CW, $clog2(DEPTH+1), derived count/level width (localparam, not overridable)

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous clear of contents
wr_dv_i  input  1  write request
wr_data_i  input  WIDTH  write data
AF_level_i  input  CW  almost-full threshold
AF_flag_o  output  1  count >= AF_level_i
full_o  output  1  count == DEPTH
rd_en_i  input  1  read request (standard) / pop acknowledge (FWFT)
rd_dv_o  output  1  rd_data_o valid
rd_data_o  output  WIDTH  read data
AE_level_i  input  CW  almost-empty threshold
AE_flag_o  output  1  count <= AE_level_i
empty_o  output  1  count == 0
count_o  output  CW  entries held, including the FWFT output register
overflow_o  output  1  sticky: write attempted while not accepted
underflow_o  output  1  sticky: read attempted with nothing to read
err_clr_i  input  1  clears overflow_o/underflow_o

Behaviour:
- Reset is decided: one clock clk_i; rst_i asynchronous, active-high.
- Reset values:
  - pointers = 0; count_o = 0; empty_o = 1; full_o = 0.
  - rd_dv_o = 0; rd_data_o = 0; overflow_o = 0; underflow_o = 0.
  - AE_flag_o and AF_flag_o follow the combinational rules below from count 0.
- Flags: full_o, empty_o, AF_flag_o and AE_flag_o are combinational from the registered count and the level inputs.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, never by natural rollover, so non-power-of-2 depth is legal.
- Write acceptance: a write is accepted when wr_dv_i=1 and not full, OR when wr_dv_i=1, full and a read is accepted in the same cycle.
  - In FWFT mode the pop frees the slot.
  - In standard mode the read frees a slot the same cycle, and count is unchanged.
- Rejected write: the data is dropped and overflow_o is set next cycle.
- Standard mode (FWFT=0):
  - rd_en_i=1 with count>0: pop; rd_data_o is registered and rd_dv_o=1 exactly the next cycle.
  - rd_dv_o is a 1-cycle pulse per accepted read; rd_data_o holds its last value otherwise.
  - rd_en_i=1 with count==0: ignored, underflow_o set. This applies even if a write occurs the same cycle; there is no bypass.
- FWFT mode (FWFT=1):
  - An output register holds the head word; rd_dv_o=1 whenever it is valid.
  - A write into a completely empty FIFO appears on rd_data_o with rd_dv_o=1 on the cycle after the write.
  - rd_en_i=1 while rd_dv_o=1 pops the head. If further entries exist in RAM, the next word is presented the following cycle with no bubble (rd_dv_o stays 1). Otherwise rd_dv_o falls.
  - rd_en_i=1 while rd_dv_o=0 is ignored and sets underflow_o.
  - count_o includes the output-register entry.
- Count: next = count + accepted_write - accepted_read, saturating is never needed by construction.
- flush_i (synchronous):
  - Next cycle: pointers = 0, count = 0, rd_dv_o = 0, output register invalid.
  - Takes priority over same-cycle wr_dv_i/rd_en_i, which are ignored and raise no error flags.
  - Does not clear overflow_o/underflow_o.
- Error flags:
  - Set on the condition and held until err_clr_i.
  - If err_clr_i and a new error occur in the same cycle, set wins.
- RAM has a registered read port only (iCE40 EBR-inferable); no asynchronous read of storage.
- Level inputs are sampled combinationally every cycle and may change at any time.

Decomposition:
- Package fifo_pkg holds:
  - fifo_mode_e enum (FIFO_STD, FIFO_FWFT), mapped to the FWFT parameter
  - a constant function for count-width computation
  - a pointer-increment-with-wrap function parameterised by DEPTH.
- One sub-module: fifo_ram, a simple dual-port memory (1 write port, 1 registered read port, WIDTH x DEPTH, no reset on the array).
- The top level holds pointers, count, the FWFT output stage, flags and errors.

Test Plan:
- DEPTH=4, FWFT=0, after reset: write 0xAB, idle 4 cycles, rd_en_i 1 cycle -> next cycle rd_dv_o=1, rd_data_o=0xAB, empty_o=1, count_o=0.
- DEPTH=4, FWFT=0: write 0x01..0x04 -> full_o=1, AF_flag_o=1 (AF_level=3). A 5th write of 0x05 -> overflow_o=1, count_o stays 4. Reads then return 0x01..0x04 in order.
- DEPTH=5, FWFT=1: write 0x10, 0x11 back-to-back -> rd_dv_o=1 with 0x10 on the cycle after the first write. Hold rd_en_i 2 cycles -> 0x10, then 0x11 with no bubble, then rd_dv_o=0, empty_o=1.
- DEPTH=5 wrap: 12 interleaved writes/reads of 0x20..0x2B across the pointer wrap -> data order intact, count_o never exceeds 5.
- FIFO full (4 entries) with rd_en_i and wr_dv_i=0x55 in the same cycle -> count_o stays 4, no overflow_o, 0x55 is read out last. A read on empty -> underflow_o=1; err_clr_i -> both flags 0.
- 3 entries stored, flush_i together with wr_dv_i -> next cycle count_o=0, empty_o=1, rd_dv_o=0, error flags unchanged. rst_i asserted mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
